// File: rtl/matrix_vertex_transform.sv
// Applies the 4x4 signed Q8.8 model matrix to a stream of (x, y, z, 1.0)
// vertices, one matrix row per cycle, with valid/ready on both sides.
module matrix_vertex_transform #(
    parameter int          FRAC_BITS = 8,
    parameter logic [15:0] W_ONE     = 16'h0100
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [15:0][15:0] model_matrix,
    input  logic              load_matrix,
    output logic              matrix_loaded,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       in_x,
    input  logic [15:0]       in_y,
    input  logic [15:0]       in_z,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       out_x,
    output logic [15:0]       out_y,
    output logic [15:0]       out_z,
    output logic [15:0]       out_w,
    output logic              out_overflow
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state;
    logic [1:0]        row;
    logic [15:0][15:0] mat;
    logic [3:0][15:0]  vtx;
    logic              pending;
    logic              sticky;

    logic signed [31:0] prod [4];
    logic signed [33:0] acc;
    logic signed [33:0] shifted;
    logic [15:0]        res;
    logic               sat;

    // Loads are only taken in IDLE and take priority over a waiting vertex,
    // so the handshake and the load strobe are both decoded from state here.
    assign in_ready      = (state == IDLE) && !load_matrix && !pending;
    assign matrix_loaded = (state == IDLE) && (load_matrix || pending);

    // One row of the matrix-vector product: four multiplies, sum, scale, saturate.
    always_comb begin
        acc     = '0;
        shifted = '0;
        res     = '0;
        sat     = 1'b0;
        for (int c = 0; c < 4; c++) begin
            prod[c] = $signed(mat[{row, c[1:0]}]) * $signed(vtx[c]);
        end
        acc     = 34'(prod[0]) + 34'(prod[1]) + 34'(prod[2]) + 34'(prod[3]);
        shifted = acc >>> FRAC_BITS;
        if (shifted > 34'sd32767) begin
            res = 16'h7FFF;
            sat = 1'b1;
        end else if (shifted < -34'sd32768) begin
            res = 16'h8000;
            sat = 1'b1;
        end else begin
            res = shifted[15:0];
        end
    end

    // Control FSM, matrix register, deferred-load flag and registered outputs.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state        <= IDLE;
            row          <= 2'd0;
            for (int i = 0; i < 16; i++) begin
                mat[i] <= (i % 5 == 0) ? 16'h0100 : 16'h0000;
            end
            vtx          <= '0;
            pending      <= 1'b0;
            sticky       <= 1'b0;
            out_x        <= '0;
            out_y        <= '0;
            out_z        <= '0;
            out_w        <= '0;
            out_valid    <= 1'b0;
            out_overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_matrix || pending) begin
                        mat     <= model_matrix;
                        pending <= 1'b0;
                    end else if (in_valid) begin
                        vtx    <= {W_ONE, in_z, in_y, in_x};
                        row    <= 2'd0;
                        sticky <= 1'b0;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    if (load_matrix) begin
                        pending <= 1'b1;
                    end
                    case (row)
                        2'd0:    out_x <= res;
                        2'd1:    out_y <= res;
                        2'd2:    out_z <= res;
                        default: out_w <= res;
                    endcase
                    sticky <= sticky | sat;
                    row    <= row + 2'd1;
                    if (row == 2'd3) begin
                        out_valid    <= 1'b1;
                        out_overflow <= sticky | sat;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    if (load_matrix) begin
                        pending <= 1'b1;
                    end
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
